// File: rtl/plot_scheduler.sv
// Arbitrates three cell-fill requesters and a full-screen clear onto a single
// VGA pixel write port, emitting one registered pixel per cycle.
module plot_scheduler #(
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned SCREEN_HEIGHT = 240,
    parameter int unsigned CELL_WIDTH    = 5
) (
    input  logic                           iClk,
    input  logic                           iReset,
    input  logic [2:0]                     iReq,
    input  logic [23:0]                    iCellX,
    input  logic [23:0]                    iCellY,
    input  logic [8:0]                     iColour,
    input  logic                           iClear,
    input  logic [2:0]                     iClearColour,
    output logic [2:0]                     oGrant,
    output logic                           oBusy,
    output logic                           oDone,
    output logic [$clog2(SCREEN_WIDTH):0]  oX_pixel,
    output logic [$clog2(SCREEN_HEIGHT):0] oY_pixel,
    output logic [2:0]                     oColour,
    output logic                           oPlot
);

    localparam int unsigned XW      = $clog2(SCREEN_WIDTH) + 1;
    localparam int unsigned YW      = $clog2(SCREEN_HEIGHT) + 1;
    localparam int unsigned DW      = $clog2(CELL_WIDTH) + 1;
    localparam int unsigned CELLS_X = SCREEN_WIDTH / CELL_WIDTH;
    localparam int unsigned CELLS_Y = SCREEN_HEIGHT / CELL_WIDTH;

    localparam logic [XW-1:0] X_LAST = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_HEIGHT - 1);
    localparam logic [DW-1:0] D_LAST = DW'(CELL_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StFill, StClear} state_e;

    state_e        state_q, state_d;
    logic [1:0]    rr_q, rr_d;
    logic          pend_q, pend_d;
    logic [2:0]    colour_q, colour_d;
    logic [XW-1:0] x_q, x_d, base_x_q, base_x_d;
    logic [YW-1:0] y_q, y_d;
    logic [DW-1:0] dx_q, dx_d, dy_q, dy_d;
    logic          plot_q, plot_d, done_q, done_d;

    logic [2:0]    grant;
    logic [1:0]    sel, cand;
    logic          sel_valid;
    logic [7:0]    sel_cx, sel_cy;
    logic [2:0]    sel_col;
    logic          sel_in_range;
    logic          clear_now;

    // Round-robin search starting at the requester after the last one granted.
    always_comb begin
        sel       = 2'd0;
        sel_valid = 1'b0;
        cand      = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cand = 2'((int'(rr_q) + k) % 3);
            if (!sel_valid && iReq[cand]) begin
                sel_valid = 1'b1;
                sel       = cand;
            end
        end
    end

    assign sel_cx       = iCellX[8*sel +: 8];
    assign sel_cy       = iCellY[8*sel +: 8];
    assign sel_col      = iColour[3*sel +: 3];
    assign sel_in_range = (32'(sel_cx) < CELLS_X) && (32'(sel_cy) < CELLS_Y);
    // A clear arriving this very cycle already outranks any requester.
    assign clear_now    = pend_q | iClear;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        pend_d   = pend_q | iClear;
        colour_d = colour_q;
        x_d      = x_q;
        y_d      = y_q;
        base_x_d = base_x_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        plot_d   = 1'b0;
        grant    = 3'b000;
        unique case (state_q)
            StIdle: begin
                if (clear_now) begin
                    state_d  = StClear;
                    pend_d   = 1'b0;
                    colour_d = iClearColour;
                    x_d      = '0;
                    y_d      = '0;
                    plot_d   = 1'b1;
                end else if (sel_valid) begin
                    grant[sel] = 1'b1;
                    rr_d       = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
                    if (sel_in_range) begin
                        state_d  = StFill;
                        colour_d = sel_col;
                        base_x_d = XW'(32'(sel_cx) * CELL_WIDTH);
                        x_d      = base_x_d;
                        y_d      = YW'(32'(sel_cy) * CELL_WIDTH);
                        dx_d     = '0;
                        dy_d     = '0;
                        plot_d   = 1'b1;
                    end
                end
            end
            StFill: begin
                if (dx_q != D_LAST) begin
                    dx_d   = dx_q + 1'b1;
                    x_d    = x_q + 1'b1;
                    plot_d = 1'b1;
                end else if (dy_q != D_LAST) begin
                    dx_d   = '0;
                    dy_d   = dy_q + 1'b1;
                    x_d    = base_x_q;
                    y_d    = y_q + 1'b1;
                    plot_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StClear: begin
                if (x_q != X_LAST) begin
                    x_d    = x_q + 1'b1;
                    plot_d = 1'b1;
                end else if (y_q != Y_LAST) begin
                    x_d    = '0;
                    y_d    = y_q + 1'b1;
                    plot_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Done rides along with whichever pixel is the final one of the operation.
        done_d = plot_d &&
                 (((state_d == StFill) && (dx_d == D_LAST) && (dy_d == D_LAST)) ||
                  ((state_d == StClear) && (x_d == X_LAST) && (y_d == Y_LAST)));
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q  <= StIdle;
            rr_q     <= 2'd0;
            pend_q   <= 1'b0;
            colour_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            base_x_q <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            pend_q   <= pend_d;
            colour_q <= colour_d;
            x_q      <= x_d;
            y_q      <= y_d;
            base_x_q <= base_x_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    assign oGrant   = iReset ? 3'b000 : grant;
    assign oBusy    = (state_q != StIdle);
    assign oDone    = done_q;
    assign oX_pixel = x_q;
    assign oY_pixel = y_q;
    assign oColour  = colour_q;
    assign oPlot    = plot_q;

endmodule

// File: tb/tb_plot_scheduler.sv
// Self-checking bench for plot_scheduler: vector table, corner-case sequences
// and a randomized run against a pixel-queue reference model.
module tb_plot_scheduler;

    localparam int W  = 320;
    localparam int H  = 240;
    localparam int CW = 5;

    logic        iClk;
    logic        iReset;
    logic [2:0]  iReq;
    logic [23:0] iCellX;
    logic [23:0] iCellY;
    logic [8:0]  iColour;
    logic        iClear;
    logic [2:0]  iClearColour;
    logic [2:0]  oGrant;
    logic        oBusy;
    logic        oDone;
    logic [9:0]  oX_pixel;
    logic [8:0]  oY_pixel;
    logic [2:0]  oColour;
    logic        oPlot;

    plot_scheduler #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .CELL_WIDTH   (CW)
    ) dut (
        .iClk        (iClk),
        .iReset      (iReset),
        .iReq        (iReq),
        .iCellX      (iCellX),
        .iCellY      (iCellY),
        .iColour     (iColour),
        .iClear      (iClear),
        .iClearColour(iClearColour),
        .oGrant      (oGrant),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oX_pixel    (oX_pixel),
        .oY_pixel    (oY_pixel),
        .oColour     (oColour),
        .oPlot       (oPlot)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic set_slot(input int i, input int cx, input int cy, input int col);
        iCellX[8*i +: 8]  = 8'(cx);
        iCellY[8*i +: 8]  = 8'(cy);
        iColour[3*i +: 3] = 3'(col);
    endtask

    task automatic scramble();
        iCellX  = 24'($urandom);
        iCellY  = 24'($urandom);
        iColour = 9'($urandom);
    endtask

    typedef struct {
        logic [2:0] req;
        int         cx;
        int         cy;
        int         col;
        logic [2:0] grant;
        int         plots;
        int         x0;
        int         y0;
    } vec_t;

    vec_t vecs[7];

    // One request from a single requester, then 30 cycles of observed pixel stream.
    task automatic run_vec(input vec_t v, input int id);
        int   slot;
        int   bad_plot, bad_pix, bad_done, bad_busy, bad_grant;
        logic exp_plot;
        bad_plot = 0; bad_pix = 0; bad_done = 0; bad_busy = 0; bad_grant = 0;
        slot = v.req[0] ? 0 : (v.req[1] ? 1 : 2);
        scramble();
        set_slot(slot, v.cx, v.cy, v.col);
        iReq = v.req;
        @(negedge iClk);
        check($sformatf("vec%0d grant", id), oGrant, v.grant);
        tick();
        iReq = 3'b000;
        scramble();
        for (int off = 1; off <= 30; off++) begin
            @(negedge iClk);
            exp_plot = (off <= v.plots);
            if (oPlot !== exp_plot) bad_plot++;
            if (exp_plot && (oX_pixel !== 10'(v.x0 + (off - 1) % CW) ||
                             oY_pixel !== 9'(v.y0 + (off - 1) / CW) ||
                             oColour !== 3'(v.col))) bad_pix++;
            if (oDone !== ((v.plots > 0) && (off == v.plots))) bad_done++;
            if (oBusy !== exp_plot) bad_busy++;
            if (oGrant !== 3'b000) bad_grant++;
            tick();
        end
        check($sformatf("vec%0d plot pattern errors", id), bad_plot, 0);
        check($sformatf("vec%0d pixel errors", id), bad_pix, 0);
        check($sformatf("vec%0d done errors", id), bad_done, 0);
        check($sformatf("vec%0d busy errors", id), bad_busy, 0);
        check($sformatf("vec%0d stray grants", id), bad_grant, 0);
    endtask

    typedef struct {
        int x;
        int y;
        int c;
        bit d;
    } pix_t;

    pix_t mq[$];
    int   g_off[$];
    int   g_val[$];

    initial begin
        int   exp_off[4];
        int   exp_g[4];
        int   bad, cnt, nplot, ndone, done_k, gcycle, gval;
        bit   act[3];
        int   rcx[3], rcy[3], rcol[3];
        int   rr, g;
        bit   rst;
        pix_t p;
        logic [2:0] e_grant;
        logic e_plot, e_done;

        // Reset state with every input busy
        iReset = 1'b1;
        iReq = 3'b111;
        iClear = 1'b1;
        iClearColour = 3'b101;
        set_slot(0, 1, 1, 1);
        set_slot(1, 2, 2, 2);
        set_slot(2, 3, 3, 3);
        @(negedge iClk);
        check("reset grant", oGrant, 0);
        check("reset busy", oBusy, 0);
        check("reset plot", oPlot, 0);
        check("reset done", oDone, 0);
        check("reset x", oX_pixel, 0);
        check("reset y", oY_pixel, 0);
        check("reset colour", oColour, 0);
        tick();
        iReset = 1'b0;
        iReq = 3'b000;
        iClear = 1'b0;
        @(negedge iClk);
        check("idle after reset", oBusy, 0);
        tick();
        @(negedge iClk);
        check("no clear from iClear seen under reset", oBusy, 0);
        tick();

        vecs[0] = '{3'b010, 2,   3,   3'b100, 3'b010, 25, 10,  15};
        vecs[1] = '{3'b100, 64,  0,   3'b011, 3'b100, 0,  0,   0};
        vecs[2] = '{3'b001, 0,   0,   3'b111, 3'b001, 25, 0,   0};
        vecs[3] = '{3'b100, 63,  47,  3'b001, 3'b100, 25, 315, 235};
        vecs[4] = '{3'b001, 0,   48,  3'b010, 3'b001, 0,  0,   0};
        vecs[5] = '{3'b010, 255, 255, 3'b110, 3'b010, 0,  0,   0};
        vecs[6] = '{3'b100, 12,  7,   3'b101, 3'b100, 25, 60,  35};
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset at the 12th pixel of a fill, then round-robin from requester 0
        set_slot(0, 1, 2, 1);
        set_slot(1, 1, 1, 2);
        set_slot(2, 3, 3, 3);
        iReq = 3'b010;
        @(negedge iClk);
        check("rst seq first grant", oGrant, 3'b010);
        tick();
        iReq = 3'b111;
        bad = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge iClk);
            if (oPlot !== 1'b1 || oDone !== 1'b0 || oGrant !== 3'b000) bad++;
            if (c < 12) tick();
        end
        check("rst seq fill before reset", bad, 0);
        #1 iReset = 1'b1;
        #1;
        check("mid-fill reset plot", oPlot, 0);
        check("mid-fill reset busy", oBusy, 0);
        check("mid-fill reset grant", oGrant, 0);
        check("mid-fill reset done", oDone, 0);
        @(posedge iClk);
        tick();
        iReset = 1'b0;
        for (int off = 0; off <= 90; off++) begin
            if (off > 0) tick();
            @(negedge iClk);
            if (oGrant !== 3'b000) begin
                g_off.push_back(off);
                g_val.push_back(int'(oGrant));
            end
        end
        exp_off = '{0, 26, 52, 78};
        exp_g   = '{1, 2, 4, 1};
        check("rr grant count", g_off.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr grant%0d cycle", i), (i < g_off.size()) ? g_off[i] : -1,
                  exp_off[i]);
            check($sformatf("rr grant%0d value", i), (i < g_val.size()) ? g_val[i] : -1,
                  exp_g[i]);
        end
        tick();
        iReq = 3'b000;
        repeat (30) tick();

        // Clear requested together with requester 0: clear runs first
        set_slot(0, 5, 5, 2);
        iReq = 3'b001;
        iClear = 1'b1;
        iClearColour = 3'b110;
        @(negedge iClk);
        check("clear beats request", oGrant, 0);
        tick();
        iClear = 1'b0;
        nplot = 0; bad = 0; ndone = 0; done_k = -1; gcycle = -1; gval = -1;
        for (int off = 1; off <= 76900; off++) begin
            @(negedge iClk);
            if (oGrant !== 3'b000) begin
                gcycle = off;
                gval = int'(oGrant);
                break;
            end
            if (oPlot === 1'b1) begin
                if (oX_pixel !== 10'(nplot % W) || oY_pixel !== 9'(nplot / W) ||
                    oColour !== 3'b110) bad++;
                if (oDone === 1'b1) begin
                    ndone++;
                    done_k = nplot;
                end
                nplot++;
            end else begin
                if (oDone === 1'b1) ndone++;
                if (off <= 76800) bad++;
            end
            tick();
        end
        check("clear plot count", nplot, W * H);
        check("clear raster errors", bad, 0);
        check("clear done count", ndone, 1);
        check("clear done pixel index", done_k, W * H - 1);
        check("grant after clear cycle", gcycle, W * H + 1);
        check("grant after clear value", gval, 1);
        check("idle at grant after clear", oBusy, 0);
        tick();
        iReq = 3'b000;
        repeat (30) tick();

        // Randomized requesters against a pixel-queue reference model
        rr = 0;
        for (int i = 0; i < 3; i++) act[i] = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!act[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        act[i]  = 1'b1;
                        rcx[i]  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(64, 255))
                                                               : int'($urandom_range(0, 63));
                        rcy[i]  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(48, 255))
                                                               : int'($urandom_range(0, 47));
                        rcol[i] = int'($urandom_range(0, 7));
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    act[i] = 1'b0;
                end
            end
            rst = (cyc == 0) || ($urandom_range(0, 399) == 0);
            scramble();
            for (int i = 0; i < 3; i++) if (act[i]) set_slot(i, rcx[i], rcy[i], rcol[i]);
            iReq   = {act[2], act[1], act[0]};
            iReset = rst;

            e_grant = 3'b000;
            e_plot  = 1'b0;
            e_done  = 1'b0;
            p       = '{0, 0, 0, 1'b0};
            if (rst) begin
                mq.delete();
                rr = 0;
            end else if (mq.size() > 0) begin
                p      = mq.pop_front();
                e_plot = 1'b1;
                e_done = p.d;
            end else begin
                g = -1;
                for (int k = 0; k < 3; k++)
                    if (g < 0 && act[(rr + k) % 3]) g = (rr + k) % 3;
                if (g >= 0) begin
                    e_grant = 3'(1 << g);
                    rr = (g + 1) % 3;
                    act[g] = 1'b0;
                    if (rcx[g] < W / CW && rcy[g] < H / CW)
                        for (int dy = 0; dy < CW; dy++)
                            for (int dx = 0; dx < CW; dx++)
                                mq.push_back('{rcx[g] * CW + dx, rcy[g] * CW + dy, rcol[g],
                                               (dx == CW - 1) && (dy == CW - 1)});
                end
            end

            @(negedge iClk);
            check("rnd grant", oGrant, e_grant);
            check("rnd busy", oBusy, e_plot);
            check("rnd plot", oPlot, e_plot);
            check("rnd done", oDone, e_done);
            if (e_plot) begin
                check("rnd x", oX_pixel, p.x);
                check("rnd y", oY_pixel, p.y);
                check("rnd colour", oColour, p.c);
            end
            tick();
        end
        iReset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
